// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle add/sub/logic/shift ops plus an
// iterative shift-add multiply, with registered result, zero and overflow flags.
module alu_seq #(
    parameter int WIDTH = 64,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic             overflow
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   count;

    assign accept   = in_valid && in_ready;
    assign shamt    = data_2[SHW-1:0];
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (alu_op == OP_MUL) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // in_ready is held low while reset is asserted so nothing is taken mid-reset.
    always_comb begin
        in_ready  = (state == IDLE) && !reset;
        out_valid = (state == DONE);
    end

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_result = data_1 + data_2;
                alu_ovf    = (data_1[WIDTH-1] == data_2[WIDTH-1]) &&
                             (alu_result[WIDTH-1] != data_1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = data_1 - data_2;
                alu_ovf    = (data_1[WIDTH-1] != data_2[WIDTH-1]) &&
                             (alu_result[WIDTH-1] != data_1[WIDTH-1]);
            end
            OP_OR:   alu_result = data_1 | data_2;
            OP_AND:  alu_result = data_1 & data_2;
            OP_XOR:  alu_result = data_1 ^ data_2;
            OP_SLL:  alu_result = data_1 << shamt;
            OP_SRL:  alu_result = data_1 >> shamt;
            default: alu_result = '0;
        endcase
    end

    // Multiply runs WIDTH shift-add steps; the result lands on the step where count hits 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (alu_op == OP_MUL) begin
                            mcand  <= data_1;
                            mplier <= data_2;
                            acc    <= '0;
                            count  <= SHW'(WIDTH - 1);
                        end else begin
                            data_out <= alu_result;
                            zero     <= (alu_result == '0);
                            overflow <= alu_ovf;
                        end
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - 1'b1;
                    if (count == '0) begin
                        data_out <= acc_next;
                        zero     <= (acc_next == '0);
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
